// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter/sequencer: core (A) and debug (B) share one SRAM port; 2-cycle request-to-ack, one access per 3 cycles.
// Requests are held until ack; loser stays pending. Define MEM_ARB_RR_EN for round-robin, otherwise fixed B-over-A priority.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_aReq,
    input  logic              i_aWr,
    input  logic [ADDR_W-1:0] i_aAddr,
    input  logic [DATA_W-1:0] i_aData,
    output logic              o_aAck,
    output logic [DATA_W-1:0] o_aData,
    input  logic              i_bReq,
    input  logic              i_bWr,
    input  logic [ADDR_W-1:0] i_bAddr,
    input  logic [DATA_W-1:0] i_bData,
    output logic              o_bAck,
    output logic [DATA_W-1:0] o_bData,
    input  logic              i_bHold,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memData,
    input  logic [DATA_W-1:0] i_memData,
    output logic              o_memOe,
    output logic              o_memWr,
    output logic              o_memEn,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t            state;
    logic              lat_id;      // 0 = port A, 1 = port B
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;
    logic              mem_en;
    logic              mem_wr;
    logic              a_ack;
    logic              b_ack;
    logic              busy;

    logic              a_elig;
    logic              b_elig;
    logic              grant_b;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef MEM_ARB_RR_EN
    logic              last_b;
`endif

    always_comb begin
        a_elig = i_aReq & ~i_bHold;
        b_elig = i_bReq;
`ifdef MEM_ARB_RR_EN
        // On contention the port that was not granted last wins.
        grant_b = b_elig & (~a_elig | ~last_b);
`else
        grant_b = b_elig;
`endif
        sel_wr   = grant_b ? i_bWr   : i_aWr;
        sel_addr = grant_b ? i_bAddr : i_aAddr;
        sel_data = grant_b ? i_bData : i_aData;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            lat_id   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            a_rd     <= '0;
            b_rd     <= '0;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            busy     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_b   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (a_elig || b_elig) begin
                        state    <= ACCESS;
                        lat_id   <= grant_b;
                        lat_wr   <= sel_wr;
                        lat_addr <= sel_addr;
                        lat_data <= sel_data;
                        mem_en   <= 1'b1;
                        mem_wr   <= sel_wr;
                        busy     <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_b   <= grant_b;
`endif
                    end
                end
                ACCESS: begin
                    state  <= ACK;
                    mem_en <= 1'b0;
                    mem_wr <= 1'b0;
                    a_ack  <= ~lat_id;
                    b_ack  <= lat_id;
                    if (!lat_wr) begin
                        if (lat_id) b_rd <= i_memData;
                        else        a_rd <= i_memData;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_wr <= 1'b0;
                    a_ack  <= 1'b0;
                    b_ack  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_memAddr = lat_addr;
    assign o_memData = lat_data;
    assign o_memEn   = mem_en;
    assign o_memWr   = mem_wr;
    assign o_memOe   = mem_wr;
    assign o_aAck    = a_ack;
    assign o_bAck    = b_ack;
    assign o_aData   = a_rd;
    assign o_bData   = b_rd;
    assign o_busy    = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level timing model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_req, a_wr, b_req, b_wr, hold;
    logic [15:0] a_addr, a_data, b_addr, b_data;
    logic        a_ack, b_ack, mem_oe, mem_wr, mem_en, busy;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_aReq(a_req), .i_aWr(a_wr), .i_aAddr(a_addr), .i_aData(a_data),
        .o_aAck(a_ack), .o_aData(a_rdata),
        .i_bReq(b_req), .i_bWr(b_wr), .i_bAddr(b_addr), .i_bData(b_data),
        .o_bAck(b_ack), .o_bData(b_rdata),
        .i_bHold(hold),
        .o_memAddr(mem_addr), .o_memData(mem_wdata), .i_memData(mem_rdata),
        .o_memOe(mem_oe), .o_memWr(mem_wr), .o_memEn(mem_en), .o_busy(busy)
    );

    logic [15:0] sram    [0:255];
    logic [15:0] ref_mem [0:255];
    assign mem_rdata = sram[mem_addr[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction model: a grant taken at edge k occupies cycles k (access) and k+1 (ack);
    // the next grant can be taken no earlier than edge k+3.
    int          cyc, free_edge, acc_edge;
    logic        m_port, m_wr, last_b;
    logic [15:0] m_addr, m_data, m_rd, exp_a, exp_b;
    logic        rand_mode, auto_drop, seen_a, seen_b;
    int          en_cnt, wr_cnt, busy_cnt, aack_cnt;
    logic [15:0] wr_a, wr_d;
    logic        obs[$];

    task automatic model_reset();
        free_edge = cyc + 1; acc_edge = -10;
        m_port = 1'b0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_rd = '0;
        exp_a = '0; exp_b = '0; last_b = 1'b0;
    endtask

    task automatic model_decide();
        int   k;
        logic ae, be, pb;
        k  = cyc + 1;
        ae = a_req && !hold;
        be = b_req;
        if (k >= free_edge && (ae || be)) begin
`ifdef MEM_ARB_RR_EN
            if (ae && be) pb = !last_b;
            else          pb = be;
`else
            pb = be;
`endif
            last_b   = pb;
            m_port   = pb;
            m_wr     = pb ? b_wr   : a_wr;
            m_addr   = pb ? b_addr : a_addr;
            m_data   = pb ? b_data : a_data;
            acc_edge = k;
            free_edge = k + 3;
            if (m_wr) ref_mem[m_addr[7:0]] = m_data;
            else      m_rd = ref_mem[m_addr[7:0]];
        end
    endtask

    task automatic step();
        logic        we, in_acc, in_ack;
        logic [15:0] wa, wd;
        model_decide();
        @(negedge clk);
        we = mem_en && mem_wr; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        if (we) sram[wa[7:0]] = wd;
        cyc++;
        #1;
        in_acc = (cyc == acc_edge);
        in_ack = (cyc == acc_edge + 1);
        if (in_ack && !m_wr) begin
            if (m_port) exp_b = m_rd;
            else        exp_a = m_rd;
        end
        check("busy",    busy,      in_acc || in_ack);
        check("mem_en",  mem_en,    in_acc);
        check("mem_wr",  mem_wr,    in_acc && m_wr);
        check("mem_oe",  mem_oe,    in_acc && m_wr);
        check("a_ack",   a_ack,     in_ack && !m_port);
        check("b_ack",   b_ack,     in_ack && m_port);
        check("mem_addr", mem_addr, m_addr);
        check("mem_data", mem_wdata, m_data);
        check("a_data",  a_rdata,   exp_a);
        check("b_data",  b_rdata,   exp_b);
        if (mem_en) en_cnt++;
        if (mem_wr) begin wr_cnt++; wr_a = mem_addr; wr_d = mem_wdata; end
        if (busy) busy_cnt++;
        if (a_ack) begin aack_cnt++; obs.push_back(1'b0); end
        if (b_ack) obs.push_back(1'b1);
        seen_a = a_ack; seen_b = b_ack;
        if (auto_drop && a_ack) a_req = 1'b0;
        if (auto_drop && b_ack) b_req = 1'b0;
        if (rand_mode) begin
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1'b1; a_wr = 1'($urandom_range(0, 1));
                a_addr = 16'($urandom_range(0, 63)); a_data = 16'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1'b1; b_wr = 1'($urandom_range(0, 1));
                b_addr = 16'($urandom_range(0, 63)); b_data = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) hold = ~hold;
        end
    endtask

    task automatic run_until_ack(input logic port, input int max, output int n);
        n = 0;
        seen_a = 1'b0; seen_b = 1'b0;
        while (!(port ? seen_b : seen_a) && n < max) begin
            step();
            n++;
        end
        check(port ? "b_ack_seen" : "a_ack_seen", port ? seen_b : seen_a, 1'b1);
    endtask

    initial begin
        int          n;
        logic [3:0]  pat;
        logic [15:0] old;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 16'(i * 7 + 16'h0100);
            ref_mem[i] = 16'(i * 7 + 16'h0100);
        end
        sram[16'h10] = 16'hBEEF; ref_mem[16'h10] = 16'hBEEF;
        {a_req, a_wr, b_req, b_wr, hold} = '0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        rand_mode = 1'b0; auto_drop = 1'b1;
        en_cnt = 0; wr_cnt = 0; busy_cnt = 0; aack_cnt = 0; wr_a = '0; wr_d = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #10;
        check("rst_busy", busy, 1'b0);
        check("rst_en",   mem_en, 1'b0);
        check("rst_wr",   mem_wr, 1'b0);
        check("rst_oe",   mem_oe, 1'b0);
        check("rst_aack", a_ack, 1'b0);
        check("rst_back", b_ack, 1'b0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdat", mem_wdata, 16'h0000);
        check("rst_adat", a_rdata, 16'h0000);
        check("rst_bdat", b_rdata, 16'h0000);
        rstn = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        model_reset();

        // single read
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010; en_cnt = 0;
        run_until_ack(1'b0, 8, n);
        check("rd_latency", n, 2);
        check("rd_en_cycles", en_cnt, 1);
        check("rd_data", a_rdata, 16'hBEEF);
        repeat (2) step();

        // single write
        b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h00FF; b_data = 16'h1234; wr_cnt = 0;
        run_until_ack(1'b1, 8, n);
        check("wr_latency", n, 2);
        check("wr_cycles", wr_cnt, 1);
        check("wr_addr", wr_a, 16'h00FF);
        check("wr_data", wr_d, 16'h1234);
        check("wr_sram", sram[8'hFF], 16'h1234);
        repeat (2) step();

        // contention
        auto_drop = 1'b0; obs.delete();
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0020;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0030;
        n = 0;
        while (obs.size() < 4 && n < 40) begin step(); n++; end
        check("contend_cnt", obs.size(), 4);
`ifdef MEM_ARB_RR_EN
        pat = 4'b0101;
`else
        pat = 4'b1111;
`endif
        for (int i = 0; i < 4 && i < obs.size(); i++) check("contend_grant", obs[i], pat[i]);
        auto_drop = 1'b1; n = 0;
        while ((a_req || b_req || busy) && n < 30) begin step(); n++; end
        check("contend_drain", a_req || b_req, 1'b0);

        // hold
        hold = 1'b1; a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0040;
        busy_cnt = 0; aack_cnt = 0;
        repeat (10) step();
        check("hold_busy", busy_cnt, 0);
        check("hold_aack", aack_cnt, 0);
        hold = 1'b0;
        run_until_ack(1'b0, 10, n);
        check("hold_release_lat", n, 2);
        repeat (2) step();

        // randomized traffic
        rand_mode = 1'b1;
        repeat (800) step();
        rand_mode = 1'b0; hold = 1'b0; n = 0;
        while ((a_req || b_req || busy) && n < 40) begin step(); n++; end
        check("rand_drain", a_req || b_req, 1'b0);

        // reset in the middle of a write
        old = ref_mem[8'h50];
        a_req = 1'b1; a_wr = 1'b1; a_addr = 16'h0050; a_data = 16'hA5A5;
        n = 0;
        while (!mem_wr && n < 6) begin step(); n++; end
        check("rstw_in_access", mem_wr, 1'b1);
        #2 rstn = 1'b0;
        a_req = 1'b0;
        #1;
        check("rstw_wr",   mem_wr, 1'b0);
        check("rstw_en",   mem_en, 1'b0);
        check("rstw_oe",   mem_oe, 1'b0);
        check("rstw_busy", busy, 1'b0);
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        check("rstw_noack", a_ack, 1'b0);
        rstn = 1'b1;
        ref_mem[8'h50] = old;
        model_reset();
        check("rstw_sram", sram[8'h50], old);
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0050;
        run_until_ack(1'b0, 8, n);
        check("rstw_rd_lat", n, 2);
        check("rstw_rd_data", a_rdata, old);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
